xlib_avalon_bus_warb: RTL

//  N-to-1 Avalon-style burst write arbiter/mux. Merges NW write masters onto one master write port.

---
 rtl/xlib_avalon_pkg.sv | 14 +
 rtl/xlib_arb_pick.sv | 50 +++++
 rtl/xlib_avalon_bus_warb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/xlib_avalon_pkg.sv
// Shared constants and helpers for the xlib Avalon write-bus blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package xlib_avalon_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width that stays at least one bit wide for degenerate port counts.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xlib_arb_pick.sv
// Combinational request picker: fixed priority (highest index) or round-robin after ptr.
// Latency: zero, purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (request vector), ptr (last granted index, round-robin only),
//        gnt_idx (chosen index), gnt_any (at least one request present).
module xlib_arb_pick
    import xlib_avalon_pkg::*;
#(
    parameter int NW  = 4,
    parameter int ARB = ARB_FIXED,
    parameter int IW  = clog2_min1(NW)
) (
    input  logic [NW-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic found;

    always_comb begin
        gnt_idx = '0;
        gnt_any = |req;
        found   = 1'b0;
        if (ARB == ARB_RR) begin
            // First pass: lowest requester strictly above ptr.
            for (int i = 0; i < NW; i++) begin
                if (req[i] && (i > int'(ptr)) && !found) begin
                    gnt_idx = IW'(i);
                    found   = 1'b1;
                end
            end
            // Wrap-around pass: lowest requester overall.
            for (int i = 0; i < NW; i++) begin
                if (req[i] && !found) begin
                    gnt_idx = IW'(i);
                    found   = 1'b1;
                end
            end
        end else begin
            // Later indices overwrite earlier ones, so the highest index wins.
            for (int i = 0; i < NW; i++) begin
                if (req[i]) begin
                    gnt_idx = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/xlib_avalon_bus_warb.sv
// N-to-1 burst write arbiter/mux: one arbitration cycle per burst, grant held to the last beat.
// Latency: zero added (combinational master side); +1 cycle with the output skid buffer.
// Backpressure: m_wrdy (or skid-buffer full) gates s_wrdy of the granted port and freezes the beat counter.
// Ports: clk/rst (async active-high); s_w* slave-side ports packed NW-wide; m_w* merged master port;
//        m_wid granted index; busy = burst in progress.
// Build option: XLIB_AVALON_BUS_W_OREG_EN adds a 2-entry skid buffer registering all master outputs.
module xlib_avalon_bus_warb
    import xlib_avalon_pkg::*;
#(
    parameter int NW      = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BL      = 8,
    parameter int BI      = 1,
    parameter int DEC_CNT = 0,
    parameter int ARB     = ARB_FIXED,
    parameter int IW      = clog2_min1(NW)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [NW-1:0]    s_wrdy,
    input  logic [NW-1:0]    s_wval,
    input  logic [NW*BL-1:0] s_wlen,
    input  logic [NW*AW-1:0] s_waddr,
    input  logic [NW*DW-1:0] s_wdata,
    input  logic             m_wrdy,
    output logic             m_wval,
    output logic [BL-1:0]    m_wlen,
    output logic [AW-1:0]    m_waddr,
    output logic [DW-1:0]    m_wdata,
    output logic [IW-1:0]    m_wid,
    output logic             busy
);

    localparam logic [BL-1:0] BI_V = BL'(BI);

    logic          en_q, en_d;
    logic [BL-1:0] cnt_q, cnt_d;
    logic [BL-1:0] len_q, len_d;
    logic [IW-1:0] wid_q, wid_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [BL-1:0] pick_len;
    logic          src_vld;
    logic          int_rdy;
    logic          beat;
    logic          last;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data;

    xlib_arb_pick #(
        .NW  (NW),
        .ARB (ARB),
        .IW  (IW)
    ) u_pick (
        .req     (s_wval),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    assign pick_len = s_wlen[int'(pick_idx)*BL +: BL];
    assign src_addr = s_waddr[int'(wid_q)*AW +: AW];
    assign src_data = s_wdata[int'(wid_q)*DW +: DW];
    assign src_vld  = en_q & s_wval[wid_q];
    assign beat     = src_vld & int_rdy;
    // len below BI makes the first beat the last one in both count modes.
    assign last     = (DEC_CNT != 0) ? (cnt_q <= BI_V) : (cnt_q >= len_q);
    assign busy     = en_q;

    always_comb begin
        s_wrdy = '0;
        if (en_q && int_rdy) begin
            s_wrdy[wid_q] = 1'b1;
        end
    end

    always_comb begin
        en_d     = en_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        wid_d    = wid_q;
        rr_ptr_d = rr_ptr_q;
        if (!en_q) begin
            // Grant cycle: no beat moves here, only the burst parameters are captured.
            if (pick_any) begin
                en_d     = 1'b1;
                wid_d    = pick_idx;
                len_d    = pick_len;
                cnt_d    = (DEC_CNT != 0) ? pick_len : BI_V;
                rr_ptr_d = pick_idx;
            end
        end else if (beat) begin
            if (last) begin
                en_d = 1'b0;
            end else begin
                cnt_d = (DEC_CNT != 0) ? (cnt_q - BL'(1)) : (cnt_q + BL'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            wid_q    <= '0;
            rr_ptr_q <= IW'(NW - 1);
        end else begin
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            wid_q    <= wid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef XLIB_AVALON_BUS_W_OREG_EN
    localparam int PW = BL + AW + DW + IW;

    logic [PW-1:0] sk0_q, sk0_d, sk1_q, sk1_d;
    logic          sk_wp_q, sk_wp_d, sk_rp_q, sk_rp_d;
    logic [1:0]    sk_cnt_q, sk_cnt_d;
    logic          sk_pop;
    logic [PW-1:0] sk_in;

    // Accepting while not full keeps one beat per cycle in steady state (push and pop together).
    assign int_rdy = (sk_cnt_q != 2'd2);
    assign sk_pop  = (sk_cnt_q != 2'd0) & m_wrdy;
    assign sk_in   = {len_q, src_addr, src_data, wid_q};

    always_comb begin
        sk0_d    = sk0_q;
        sk1_d    = sk1_q;
        sk_wp_d  = sk_wp_q;
        sk_rp_d  = sk_rp_q;
        sk_cnt_d = sk_cnt_q + {1'b0, beat} - {1'b0, sk_pop};
        if (beat) begin
            if (sk_wp_q) begin
                sk1_d = sk_in;
            end else begin
                sk0_d = sk_in;
            end
            sk_wp_d = ~sk_wp_q;
        end
        if (sk_pop) begin
            sk_rp_d = ~sk_rp_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk0_q    <= '0;
            sk1_q    <= '0;
            sk_wp_q  <= 1'b0;
            sk_rp_q  <= 1'b0;
            sk_cnt_q <= 2'd0;
        end else begin
            sk0_q    <= sk0_d;
            sk1_q    <= sk1_d;
            sk_wp_q  <= sk_wp_d;
            sk_rp_q  <= sk_rp_d;
            sk_cnt_q <= sk_cnt_d;
        end
    end

    assign m_wval = (sk_cnt_q != 2'd0);
    assign {m_wlen, m_waddr, m_wdata, m_wid} = sk_rp_q ? sk1_q : sk0_q;
`else
    assign int_rdy = m_wrdy;
    assign m_wval  = src_vld;
    assign m_wlen  = len_q;
    assign m_waddr = src_addr;
    assign m_wdata = src_data;
    assign m_wid   = wid_q;
`endif

endmodule
